// File: rtl/wb_csr_master_pkg.sv
// Shared definitions for the Wishbone-to-CSR bridge.
//   CSR_AW_DEFAULT      default CSR word-address width
//   CSR_RD_LAT_DEFAULT  default CSR read latency (cycles, 1..3)
//   state_t             bridge FSM state encoding
package wb_csr_master_pkg;

  localparam int CSR_AW_DEFAULT     = 14;
  localparam int CSR_RD_LAT_DEFAULT = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RMW_WAIT = 3'd2,
    ST_WRITE    = 3'd3,
    ST_ACK      = 3'd4
  } state_t;

endpackage

// File: rtl/wb_csr_master_if.sv
// Wishbone classic single-cycle bus between the system interconnect
// (master modport) and a bridge acting as slave (slave modport).
//   wb_adr_i/wb_dat_i/wb_sel_i  address, write data, byte selects
//   wb_stb_i/wb_cyc_i/wb_we_i   strobe, cycle, write enable
//   wb_dat_o/wb_ack_o           read data, one-cycle acknowledge
interface wb_csr_master_if;

  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/csr_byte_merge.sv
// Combinational byte merge for read-modify-write on the CSR bus.
//   old_word  current register contents read from the peripheral
//   new_word  write data from the initiator
//   sel       byte selects; bit n picks new_word[8n+7:8n]
//   merged    resulting word to write back
module csr_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  sel,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/wb_csr_master.sv
// Wishbone classic slave to CSR-bus master bridge. Full-word reads and
// writes map to single CSR accesses; partial byte-select writes become a
// read-modify-write so unselected bytes are preserved.
//   sys_clk, sys_rst_n  clock, async active-low reset
//   wb                  Wishbone slave side (wb_csr_master_if.slave)
//   csr_a/csr_we/csr_do CSR initiator address, write strobe, write data
//   csr_di              OR-ed read data from the CSR peripherals
//
// state       | meaning
// ST_IDLE     | waiting for a request; csr_a holds last address
// ST_RD_WAIT  | counting down CSR read latency for a read
// ST_RMW_WAIT | counting down read latency before the merged write
// ST_WRITE    | csr_we pulse in flight; ack issued on the next edge
// ST_ACK      | ack visible for one cycle; requests not sampled
module wb_csr_master
  import wb_csr_master_pkg::*;
#(
  parameter int CSR_AW = CSR_AW_DEFAULT,
  parameter int RD_LAT = CSR_RD_LAT_DEFAULT
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  wb_csr_master_if.slave    wb,
  output logic [CSR_AW-1:0] csr_a,
  output logic              csr_we,
  output logic [31:0]       csr_do,
  input  logic [31:0]       csr_di
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  state_t             state, state_nx;
  logic [1:0]         cnt, cnt_nx;
  logic [31:0]        wdat, wdat_nx;
  logic [3:0]         wsel, wsel_nx;
  logic               ack_q, ack_nx;
  logic [31:0]        dat_q, dat_nx;
  logic [CSR_AW-1:0]  a_nx;
  logic               we_nx;
  logic [31:0]        do_nx;
  logic [31:0]        merged;
  logic               req;

  // Address bits outside the CSR word address are deliberately ignored.
  logic unused_adr;
  assign unused_adr = ^{wb.wb_adr_i[31:CSR_AW+2], wb.wb_adr_i[1:0]};

  assign req = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;

  csr_byte_merge u_merge (
    .old_word (csr_di),
    .new_word (wdat),
    .sel      (wsel),
    .merged   (merged)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    wdat_nx  = wdat;
    wsel_nx  = wsel;
    ack_nx   = 1'b0;
    dat_nx   = dat_q;
    a_nx     = csr_a;
    we_nx    = 1'b0;
    do_nx    = csr_do;
    case (state)
      ST_IDLE: begin
        if (req) begin
          a_nx = wb.wb_adr_i[CSR_AW+1:2];
          if (!wb.wb_we_i) begin
            cnt_nx   = LAT;
            state_nx = ST_RD_WAIT;
          end else if (wb.wb_sel_i == 4'hF) begin
            do_nx    = wb.wb_dat_i;
            we_nx    = 1'b1;
            state_nx = ST_WRITE;
          end else if (wb.wb_sel_i == 4'h0) begin
            ack_nx   = 1'b1;
            state_nx = ST_ACK;
          end else begin
            wdat_nx  = wb.wb_dat_i;
            wsel_nx  = wb.wb_sel_i;
            cnt_nx   = LAT;
            state_nx = ST_RMW_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (cnt == 2'd0) begin
          dat_nx   = csr_di;
          // An abandoned cycle still finishes its CSR access, but no ack.
          ack_nx   = wb.wb_cyc_i;
          state_nx = ST_ACK;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      ST_RMW_WAIT: begin
        if (cnt == 2'd0) begin
          do_nx    = merged;
          we_nx    = 1'b1;
          state_nx = ST_WRITE;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      ST_WRITE: begin
        ack_nx   = wb.wb_cyc_i;
        state_nx = ST_ACK;
      end
      ST_ACK: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= ST_IDLE;
      cnt    <= 2'd0;
      wdat   <= 32'd0;
      wsel   <= 4'd0;
      ack_q  <= 1'b0;
      dat_q  <= 32'd0;
      csr_a  <= '0;
      csr_we <= 1'b0;
      csr_do <= 32'd0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      wdat   <= wdat_nx;
      wsel   <= wsel_nx;
      ack_q  <= ack_nx;
      dat_q  <= dat_nx;
      csr_a  <= a_nx;
      csr_we <= we_nx;
      csr_do <= do_nx;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

endmodule
